// File: rtl/ifu_fetch_if.sv
// Fetch-unit bus bundle: instruction-memory request, execute redirect and
// the decode-side valid/ready stream.
interface ifu_fetch_if #(
    parameter int INST_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  imem_valid;
    logic                  imem_ready;
    logic [ADDR_WIDTH-1:0] imem_pc;
    logic [INST_WIDTH-1:0] imem_inst;
    logic                  redirect_valid;
    logic [ADDR_WIDTH-1:0] redirect_pc;
    logic                  out_valid;
    logic                  out_ready;
    logic [ADDR_WIDTH-1:0] out_pc;
    logic [INST_WIDTH-1:0] out_inst;

    modport master (
        output imem_valid, imem_pc, out_valid, out_pc, out_inst,
        input  imem_ready, imem_inst, redirect_valid, redirect_pc, out_ready
    );

    modport slave (
        input  imem_valid, imem_pc, out_valid, out_pc, out_inst,
        output imem_ready, imem_inst, redirect_valid, redirect_pc, out_ready
    );
endinterface

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, fetches from a same-cycle instruction
// memory and queues {pc, inst} pairs toward decode; redirects flush the queue.
module ifu_fetch #(
    parameter int                    INST_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h8000_0000,
    parameter int                    FIFO_DEPTH = 2
) (
    input  logic         clock,
    input  logic         reset,
    ifu_fetch_if.master  bus_io
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [CW-1:0]         count_q, count_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;

    logic [ADDR_WIDTH-1:0] pc_mem   [FIFO_DEPTH];
    logic [INST_WIDTH-1:0] inst_mem [FIFO_DEPTH];

    logic fetch_fire;
    logic pop;

    // The request depends only on registered occupancy, never on out_ready.
    assign bus_io.imem_valid = !reset && (state_q == RUN) &&
                               (count_q < CW'(FIFO_DEPTH)) && !bus_io.redirect_valid;
    assign bus_io.imem_pc    = pc_q;
    assign bus_io.out_valid  = (count_q != '0) && !bus_io.redirect_valid && !reset;
    assign bus_io.out_pc     = pc_mem[rd_ptr_q];
    assign bus_io.out_inst   = inst_mem[rd_ptr_q];

    assign fetch_fire = bus_io.imem_valid && bus_io.imem_ready;
    assign pop        = bus_io.out_valid && bus_io.out_ready;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;

        case (state_q)
            BOOT:    state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = BOOT;
        endcase

        if (bus_io.redirect_valid) begin
            pc_d     = {bus_io.redirect_pc[ADDR_WIDTH-1:2], 2'b00};
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (fetch_fire) begin
                pc_d     = pc_q + ADDR_WIDTH'(4);
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(fetch_fire) - CW'(pop);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= BOOT;
            pc_q     <= RESET_PC;
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    // Queue storage carries no reset; fetch_fire is already low in reset and redirect.
    always_ff @(posedge clock) begin
        if (fetch_fire) begin
            pc_mem[wr_ptr_q]   <= pc_q;
            inst_mem[wr_ptr_q] <= bus_io.imem_inst;
        end
    end
endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: directed scenarios plus random traffic, checked every
// cycle against a queue-based model of the fetch/decode stream.
module tb_ifu_fetch;
    localparam logic [31:0] RST_PC = 32'h8000_0000;
    localparam logic [31:0] SALT   = 32'hA5A5_0000;
    localparam int          DEPTH  = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;

    ifu_fetch_if #(.INST_WIDTH(32), .ADDR_WIDTH(32)) bus ();

    ifu_fetch #(
        .INST_WIDTH(32), .ADDR_WIDTH(32), .RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .bus_io (bus)
    );

    always #5 clock = ~clock;

    // Memory model: instruction is a fixed function of the requested address.
    assign bus.imem_inst = bus.imem_pc ^ SALT;

    int total  = 0;
    int passed = 0;

    logic [31:0] mq_pc[$];
    logic [31:0] mq_inst[$];
    logic [31:0] m_pc   = '0;
    bit          m_boot = 1'b1;
    bit          m_init = 1'b0;

    int          cyc = 0;
    logic [31:0] fetch_pc[$];
    int          fetch_cyc[$];
    logic [31:0] pop_pc[$];
    int          pop_cyc[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        else passed++;
    endtask

    task automatic clear_logs();
        fetch_pc.delete();
        fetch_cyc.delete();
        pop_pc.delete();
        pop_cyc.delete();
    endtask

    task automatic step(input bit rst, input bit rv, input logic [31:0] rpc,
                        input bit ir, input bit ordy);
        bit exp_iv, exp_ov, fire, pp;
        @(negedge clock);
        reset              = rst;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        bus.imem_ready     = ir;
        bus.out_ready      = ordy;
        #1;
        exp_iv = !rst && !m_boot && (mq_pc.size() < DEPTH) && !rv;
        exp_ov = !rst && (mq_pc.size() > 0) && !rv;
        check("imem_valid", 32'(bus.imem_valid), 32'(exp_iv));
        if (!rst && m_init) check("imem_pc", bus.imem_pc, m_pc);
        check("out_valid", 32'(bus.out_valid), 32'(exp_ov));
        if (exp_ov) begin
            check("out_pc", bus.out_pc, mq_pc[0]);
            check("out_inst", bus.out_inst, mq_inst[0]);
        end

        if (rst) cyc = 0;
        else     cyc++;
        if (bus.imem_valid && ir) begin
            fetch_pc.push_back(bus.imem_pc);
            fetch_cyc.push_back(cyc);
        end
        if (bus.out_valid && ordy) begin
            pop_pc.push_back(bus.out_pc);
            pop_cyc.push_back(cyc);
        end

        if (rst) begin
            mq_pc.delete();
            mq_inst.delete();
            m_pc   = RST_PC;
            m_boot = 1'b1;
            m_init = 1'b1;
        end else if (rv) begin
            mq_pc.delete();
            mq_inst.delete();
            m_pc   = {rpc[31:2], 2'b00};
            m_boot = 1'b0;
        end else begin
            fire = exp_iv && ir;
            pp   = exp_ov && ordy;
            if (pp) begin
                void'(mq_pc.pop_front());
                void'(mq_inst.pop_front());
            end
            if (fire) begin
                mq_pc.push_back(m_pc);
                mq_inst.push_back(m_pc ^ SALT);
                m_pc = m_pc + 32'd4;
            end
            m_boot = 1'b0;
        end
    endtask

    task automatic run(input int n, input bit ir, input bit ordy);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, ir, ordy);
    endtask

    initial begin
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.imem_ready     = 1'b0;
        bus.out_ready      = 1'b0;

        // Reset release and steady streaming
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0, 1'b1, 1'b1);
        clear_logs();
        run(6, 1'b1, 1'b1);
        check("s1 fetch seen", 32'(fetch_pc.size() >= 1), 32'd1);
        check("s1 pops seen", 32'(pop_pc.size() >= 3), 32'd1);
        if (fetch_pc.size() >= 1 && pop_pc.size() >= 3) begin
            check("s1 first fetch cycle", 32'(fetch_cyc[0]), 32'd2);
            check("s1 first fetch pc", fetch_pc[0], 32'h8000_0000);
            check("s1 pop0 pc", pop_pc[0], 32'h8000_0000);
            check("s1 pop1 pc", pop_pc[1], 32'h8000_0004);
            check("s1 pop2 pc", pop_pc[2], 32'h8000_0008);
            check("s1 pop0 cycle", 32'(pop_cyc[0]), 32'd3);
            check("s1 pop2 cycle", 32'(pop_cyc[2]), 32'd5);
        end

        // Decode stalled: the queue fills with two entries and fetch stops
        for (int i = 0; i < 2; i++) step(1'b1, 1'b0, '0, 1'b1, 1'b0);
        clear_logs();
        run(6, 1'b1, 1'b0);
        check("s2 fetch count", 32'(fetch_pc.size()), 32'd2);
        check("s2 full no request", 32'(bus.imem_valid), 32'd0);
        check("s2 held pc", bus.imem_pc, 32'h8000_0008);
        run(1, 1'b1, 1'b1);
        check("s2 no request on pop", 32'(bus.imem_valid), 32'd0);
        run(1, 1'b1, 1'b1);
        check("s2 resume fetch pc", fetch_pc[fetch_pc.size()-1], 32'h8000_0008);
        check("s2 pop order", pop_pc[0], 32'h8000_0000);
        run(2, 1'b1, 1'b1);

        // Redirect with a full queue
        run(3, 1'b1, 1'b0);
        step(1'b0, 1'b1, 32'h8000_0103, 1'b1, 1'b1);
        check("s3 out_valid in redirect", 32'(bus.out_valid), 32'd0);
        check("s3 imem_valid in redirect", 32'(bus.imem_valid), 32'd0);
        clear_logs();
        run(1, 1'b0, 1'b0);
        check("s3 new pc", bus.imem_pc, 32'h8000_0100);
        check("s3 empty after redirect", 32'(bus.out_valid), 32'd0);
        run(4, 1'b1, 1'b1);
        check("s3 first pop pc", (pop_pc.size() > 0) ? pop_pc[0] : 32'hDEAD_DEAD, 32'h8000_0100);

        // Memory stall pattern 1,0,0,1
        clear_logs();
        step(1'b0, 1'b0, '0, 1'b1, 1'b1);
        step(1'b0, 1'b0, '0, 1'b0, 1'b1);
        step(1'b0, 1'b0, '0, 1'b0, 1'b1);
        step(1'b0, 1'b0, '0, 1'b1, 1'b1);
        run(2, 1'b1, 1'b1);
        check("s4 fetch count", 32'(fetch_pc.size()), 32'd4);

        // PC wrap
        step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1);
        clear_logs();
        run(3, 1'b1, 1'b1);
        check("s5 fetches seen", 32'(fetch_pc.size() >= 2), 32'd1);
        if (fetch_pc.size() >= 2) begin
            check("s5 fetch before wrap", fetch_pc[0], 32'hFFFF_FFFC);
            check("s5 fetch after wrap", fetch_pc[1], 32'h0000_0000);
        end

        // Reset mid-stream with a full queue
        run(3, 1'b1, 1'b0);
        step(1'b1, 1'b0, '0, 1'b1, 1'b1);
        check("s6 out_valid in reset", 32'(bus.out_valid), 32'd0);
        check("s6 imem_valid in reset", 32'(bus.imem_valid), 32'd0);
        clear_logs();
        run(4, 1'b1, 1'b1);
        check("s6 refetch seen", 32'(fetch_pc.size() >= 1), 32'd1);
        if (fetch_pc.size() >= 1) begin
            check("s6 refetch pc", fetch_pc[0], 32'h8000_0000);
            check("s6 refetch cycle", 32'(fetch_cyc[0]), 32'd2);
        end

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            bit          r_rst, r_rv;
            logic [31:0] r_pc;
            r_rst = ($urandom_range(99) == 0);
            r_rv  = ($urandom_range(19) == 0);
            r_pc  = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15)))
                                             : $urandom;
            step(r_rst, r_rv, r_pc, ($urandom_range(3) != 0), $urandom_range(1) == 1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction fetch unit sitting directly upstream of the simulated instruction memory.
- Owns the program counter and drives the memory's valid/pc request, capturing the combinationally returned instruction in the same cycle.
- Buffers {pc, inst} pairs in a small FIFO toward decode using a valid/ready handshake.
- Handles redirects (branch/jump/trap) from the execute stage by flushing the FIFO and reloading the PC.

Parameters:
- INST_WIDTH, 32, instruction width in bits.
- ADDR_WIDTH, 32, PC/address width in bits.
- RESET_PC, 32'h8000_0000, PC value loaded on reset.
- FIFO_DEPTH, 2, number of {pc, inst} entries buffered toward decode (power of two, ≥2).

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_valid  out  1  fetch request to instruction memory.
- imem_ready  in  1  memory accepts the request; the instruction is valid in the same cycle.
- imem_pc  out  ADDR_WIDTH  fetch address; always equals the current PC register.
- imem_inst  in  INST_WIDTH  instruction returned combinationally for imem_pc.
- redirect_valid  in  1  flush and redirect request from execute.
- redirect_pc  in  ADDR_WIDTH  redirect target.
- out_valid  out  1  the FIFO head is valid toward decode.
- out_ready  in  1  decode accepts the head.
- out_pc  out  ADDR_WIDTH  PC of the head entry.
- out_inst  out  INST_WIDTH  instruction of the head entry.

Behaviour:
- Reset is synchronous and active-high. While reset is high:
  - pc <= RESET_PC, count <= 0, rd/wr pointers <= 0, state <= BOOT.
  - imem_valid = 0 and out_valid = 0, both gated combinationally by reset.
  - out_pc and out_inst hold their last values and are don't-care while out_valid = 0.
- State machine has two states:
  - BOOT: one cycle after reset deasserts with no fetch (imem_valid = 0), letting the memory model initialise. Transitions to RUN unconditionally. A redirect during BOOT still loads pc and moves to RUN.
  - RUN: normal operation. Never leaves RUN except via reset.
- Fetch request:
  - imem_valid = (state == RUN) && (count < FIFO_DEPTH) && !redirect_valid.
  - No combinational path from out_ready to imem_valid. A full FIFO does not request even if decode pops in the same cycle.
- fetch_fire = imem_valid && imem_ready. On fire:
  - Write {pc, imem_inst} at wr_ptr.
  - wr_ptr++ (wraps modulo FIFO_DEPTH).
  - pc <= pc + 4, wrapping modulo 2^ADDR_WIDTH (ADDR_WIDTH-bit truncated add; no carry out).
- Decode handshake:
  - out_valid = (count != 0) && !redirect_valid && !reset.
  - out_pc and out_inst come from the entry at rd_ptr (registered storage, not a bypass).
  - pop = out_valid && out_ready. On pop, rd_ptr++ (wraps).
  - Entries are presented in strict fetch order.
  - No fetch-to-decode bypass: an instruction fetched in cycle N appears on out_* no earlier than cycle N+1.
- count update:
  - count <= count + fetch_fire - pop.
  - Simultaneous fire and pop with 0 < count < DEPTH leaves count unchanged and both pointers advance.
- Redirect has priority over fetch and pop. When redirect_valid is high in a cycle:
  - count <= 0 and rd_ptr <= wr_ptr <= 0.
  - pc <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00}; the low two bits are forced to zero.
  - No push and no pop occur.
  - Fetch from the new PC begins the following cycle.
- Back-to-back redirects: the last one wins; each clears the FIFO.
- Reset mid-operation: all in-flight entries are discarded and the next fetch is at RESET_PC, issued 2 cycles after reset deasserts (the BOOT cycle plus the first RUN cycle).
- When imem_ready = 0, pc holds and the request stays asserted with the same imem_pc until accepted or redirected.
- Steady state: with imem_ready = 1 and out_ready = 1, throughput is 1 instruction per cycle after a 1-cycle fill latency.

Test Plan:
- Reset release, imem_ready = 1, out_ready = 1, memory returns inst = pc ^ 32'hA5A5_0000 → first imem_valid in cycle 2 after reset deasserts with pc = 32'h8000_0000. Decode then sees pc 8000_0000, 8000_0004, 8000_0008 on consecutive cycles with matching insts.
- out_ready = 0 for 5 cycles → exactly 2 fetches (8000_0000, 8000_0004), then imem_valid = 0 with imem_pc = 8000_0008. Raising out_ready drains in order, and fetching resumes the cycle after the first pop.
- FIFO holds 1 entry, imem_ready = 1, out_ready = 1 for 4 cycles → count stays 1 and the out_pc sequence is gapless (+4 each cycle).
- redirect_valid with redirect_pc = 32'h8000_0103 while count = 2 → out_valid = 0 that cycle, FIFO empty next cycle, next imem_pc = 8000_0100, and no stale entry ever reaches decode.
- imem_ready toggling 1,0,0,1 → imem_pc holds across the stall cycles and no duplicate or skipped PCs appear at decode.
- PC wrap: redirect to 32'hFFFF_FFFC → fetches FFFF_FFFC then 0000_0000. Also assert reset mid-stream with count = 2 → out_valid = 0 immediately and refetch from 8000_0000.
